// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for the fetch path
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_UPDATE,
    ST_HALTED,
    ST_FAULT
  } fetch_state_t;

  // Must match the program_counter select encoding.
  localparam logic PC_SEL_INC = 1'b0;
  localparam logic PC_SEL_BUS = 1'b1;

  localparam logic [15:0] RESET_IR = 16'h0000;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// rtl/fetch_timeout_ctr.sv - counts FETCH wait cycles, flags the last allowed one
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch controller driving program_counter
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic [ADDR_W-1:0] pc_value,
  output logic              pc_enable,
  output logic              pc_select,
  output logic [ADDR_W-1:0] pc_bus,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_valid,
  input  logic              ir_ack,
  input  logic              branch_take,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [15:0]       retired,
  output logic              halted,
  output logic              fault
);

  fetch_state_t r_state;
  fetch_state_t w_next;

  logic              w_ctr_inc;
  logic              w_ctr_clr;
  logic              w_expired;
  logic [DATA_W-1:0] r_ir;
  logic              r_pc_select;
  logic [ADDR_W-1:0] r_pc_bus;
  logic [15:0]       r_retired;

  assign w_ctr_inc = (r_state == ST_FETCH) && !mem_rdy;
  assign w_ctr_clr = !w_ctr_inc;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_ctr_clr),
    .inc     (w_ctr_inc),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    ir_valid  = 1'b0;
    pc_enable = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    case (r_state)
      ST_IDLE:   w_next = halt ? ST_HALTED : ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        // A response in the final allowed cycle still counts as a hit.
        if (mem_rdy) begin
          w_next = ST_HOLD;
        end else if (w_expired) begin
          w_next = ST_FAULT;
        end
      end
      ST_HOLD: begin
        ir_valid = 1'b1;
        if (ir_ack) begin
          w_next = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        pc_enable = 1'b1;
        w_next    = halt ? ST_HALTED : ST_FETCH;
      end
      ST_HALTED: begin
        halted = 1'b1;
        if (!halt) begin
          w_next = ST_FETCH;
        end
      end
      ST_FAULT:  fault = 1'b1;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir        <= DATA_W'(RESET_IR);
      r_pc_select <= PC_SEL_INC;
      r_pc_bus    <= '0;
      r_retired   <= '0;
    end else begin
      if (r_state == ST_FETCH && mem_rdy) begin
        r_ir <= mem_rdata;
      end
      if (r_state == ST_HOLD && ir_ack) begin
        r_pc_select <= branch_take;
        if (branch_take) begin
          r_pc_bus <= branch_target;
        end
      end else if (w_next == ST_FETCH && r_state != ST_FETCH) begin
        r_pc_select <= PC_SEL_INC;
      end
      if (r_state == ST_UPDATE) begin
        r_retired <= r_retired + 16'd1;
      end
    end
  end

  assign mem_addr  = mem_req ? pc_value : '0;
  assign ir_out    = r_ir;
  assign pc_select = r_pc_select;
  assign pc_bus    = r_pc_bus;
  assign retired   = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] pc_value;
  logic        pc_enable;
  logic        pc_select;
  logic [15:0] pc_bus;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_rdy = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic        ir_ack = 1'b0;
  logic        branch_take = 1'b0;
  logic [15:0] branch_target = '0;
  logic [15:0] retired;
  logic        halted;
  logic        fault;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        sel;
    logic [15:0] bus;
    logic [15:0] ret;
  } upd_t;

  logic [15:0] fetch_q[$];
  logic [15:0] hold_q[$];
  upd_t        upd_q[$];
  logic [15:0] mon_e;
  upd_t        mon_u;

  fetch_sequencer #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .halt(halt), .pc_value(pc_value),
    .pc_enable(pc_enable), .pc_select(pc_select), .pc_bus(pc_bus),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdy(mem_rdy),
    .mem_rdata(mem_rdata), .ir_out(ir_out), .ir_valid(ir_valid),
    .ir_ack(ir_ack), .branch_take(branch_take), .branch_target(branch_target),
    .retired(retired), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // Behavioural program_counter
  always @(posedge clk or posedge rst) begin
    if (rst) pc_value <= '0;
    else if (pc_enable) pc_value <= pc_select ? pc_bus : pc_value + 16'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && mem_rdy) begin
        if (fetch_q.size() == 0) check("unexpected_fetch", 1, 0);
        else begin
          mon_e = fetch_q.pop_front();
          check("fetch_addr", mem_addr, mon_e);
        end
      end
      if (ir_valid && ir_ack) begin
        if (hold_q.size() == 0) check("unexpected_ack", 1, 0);
        else begin
          mon_e = hold_q.pop_front();
          check("ir_out", ir_out, mon_e);
        end
      end
      if (pc_enable) begin
        if (upd_q.size() == 0) check("unexpected_update", 1, 0);
        else begin
          mon_u = upd_q.pop_front();
          check("upd_pc_select", pc_select, mon_u.sel);
          check("upd_pc_bus", pc_bus, mon_u.bus);
          check("upd_retired", retired, mon_u.ret);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [15:0] addr, input logic [15:0] data, input int dly,
                           input logic take, input logic [15:0] tgt, input logic [15:0] exp_bus,
                           input logic [15:0] exp_ret, input logic hlt);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    check("fetch_seen", mem_req, 1);
    fetch_q.push_back(addr);
    hold_q.push_back(data);
    upd_q.push_back('{sel: take, bus: exp_bus, ret: exp_ret});
    for (int i = 0; i < dly; i++) begin
      step();
      check("wait_req", mem_req, 1);
      check("wait_addr", mem_addr, addr);
      check("wait_no_fault", fault, 0);
    end
    mem_rdy = 1'b1;
    mem_rdata = data;
    step();
    mem_rdy = 1'b0;
    mem_rdata = '0;
    check("hold_valid", ir_valid, 1);
    branch_take = 1'b1;
    branch_target = 16'hFFFF;
    step();
    check("hold_stays", ir_valid, 1);
    if (hlt) halt = 1'b1;
    ir_ack = 1'b1;
    branch_take = take;
    branch_target = tgt;
    step();
    ir_ack = 1'b0;
    branch_take = 1'b0;
    branch_target = '0;
    check("update_strobe", pc_enable, 1);
    check("ir_valid_fall", ir_valid, 0);
  endtask

  initial begin
    int cnt;
    #2 rst = 1'b1;
    #1;
    check("rst_pc_enable", pc_enable, 0);
    check("rst_pc_select", pc_select, 0);
    check("rst_pc_bus", pc_bus, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_ir_out", ir_out, 0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_retired", retired, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    step();
    rst = 1'b0;
    check("idle_no_req", mem_req, 0);
    step();
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, 16'h0000);

    run_instr(16'h0000, 16'h1234, 0, 1'b0, 16'h0000, 16'h0000, 16'd0, 1'b0);
    step();
    check("retired_1", retired, 16'd1);
    check("next_addr_inc", mem_addr, 16'h0001);

    run_instr(16'h0001, 16'h5678, 0, 1'b1, 16'h00A0, 16'h00A0, 16'd1, 1'b0);
    step();
    check("branch_addr", mem_addr, 16'h00A0);
    check("sel_cleared_fetch", pc_select, 0);

    run_instr(16'h00A0, 16'h9ABC, 5, 1'b0, 16'h0000, 16'h00A0, 16'd2, 1'b0);
    step();
    check("after_delay_addr", mem_addr, 16'h00A1);
    check("after_delay_fault", fault, 0);

    run_instr(16'h00A1, 16'h1111, 0, 1'b0, 16'h0000, 16'h00A0, 16'd3, 1'b1);
    step();
    check("halted_set", halted, 1);
    check("halted_no_req", mem_req, 0);
    step();
    step();
    check("halted_hold", halted, 1);
    check("halted_hold_req", mem_req, 0);
    halt = 1'b0;
    step();
    check("resume_halted", halted, 0);
    check("resume_req", mem_req, 1);
    check("resume_addr", mem_addr, 16'h00A2);

    force dut.r_retired = 16'hFFFF;
    #1;
    release dut.r_retired;
    run_instr(16'h00A2, 16'h2222, 0, 1'b0, 16'h0000, 16'h00A0, 16'hFFFF, 1'b0);
    step();
    check("retired_wrap", retired, 16'h0000);

    cnt = 1;
    while (mem_req && cnt < 40) begin
      step();
      if (mem_req) cnt++;
    end
    check("timeout_cycles", cnt, 16);
    check("fault_set", fault, 1);
    for (int i = 0; i < 4; i++) begin
      halt = ~halt;
      step();
      check("fault_sticky", fault, 1);
      check("fault_not_halted", halted, 0);
      check("fault_no_req", mem_req, 0);
    end
    halt = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_clears_fault", fault, 0);
    check("rst_fault_req", mem_req, 0);
    step();
    rst = 1'b0;

    run_instr(16'h0000, 16'h3333, 0, 1'b1, 16'h0055, 16'h0055, 16'd0, 1'b0);
    step();
    check("pre_rst_addr", mem_addr, 16'h0055);
    step();
    check("pre_rst_fetch", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_pc_enable", pc_enable, 0);
    check("mid_rst_pc_select", pc_select, 0);
    check("mid_rst_pc_bus", pc_bus, 0);
    check("mid_rst_mem_req", mem_req, 0);
    check("mid_rst_ir_out", ir_out, 0);
    check("mid_rst_ir_valid", ir_valid, 0);
    check("mid_rst_retired", retired, 0);
    check("mid_rst_halted", halted, 0);
    check("mid_rst_fault", fault, 0);
    step();
    rst = 1'b0;
    step();

    check("queues_drained", fetch_q.size() + hold_q.size() + upd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the 16-bit CPU. Sequences the existing `program_counter` through its `pc_enable`/`select`/`bus` controls, issues instruction reads to memory, and holds the fetched word in an instruction register until the decoder accepts it. Also applies branch targets to the PC, supports halt/resume, and flags a sticky fault on memory timeout.

## Interface
Parameters:
- `ADDR_W`, 16: PC and memory address width.
- `DATA_W`, 16: instruction width.
- `TIMEOUT`, 16: maximum FETCH cycles waiting for `mem_rdy`; legal range is ≥ 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `halt`  in  1  level; request stop at the instruction boundary.
- `pc_value`  in  ADDR_W  current output of `program_counter`.
- `pc_enable`  out  1  one-cycle PC update strobe.
- `pc_select`  out  1  0 = PC+1, 1 = load `pc_bus`.
- `pc_bus`  out  ADDR_W  branch target driven to the PC.
- `mem_req`  out  1  instruction read request.
- `mem_addr`  out  ADDR_W  read address; equals `pc_value` while `mem_req` = 1.
- `mem_rdy`  in  1  read data valid this cycle.
- `mem_rdata`  in  DATA_W  read data.
- `ir_out`  out  DATA_W  instruction register.
- `ir_valid`  out  1  `ir_out` is presented to the decoder.
- `ir_ack`  in  1  decoder has consumed the instruction (execute done).
- `branch_take`  in  1  sampled with `ir_ack`.
- `branch_target`  in  ADDR_W  sampled with `ir_ack`.
- `retired`  out  16  count of retired instructions.
- `halted`  out  1  controller is in the HALTED state.
- `fault`  out  1  sticky memory-timeout flag.

## Operation
States: IDLE, FETCH, HOLD, UPDATE, HALTED, FAULT. `rst` forces IDLE.
- IDLE: next state is HALTED if `halt` = 1, otherwise FETCH.
- FETCH:
  - `mem_req` = 1; `mem_addr` = `pc_value`; wait counter increments each cycle.
  - On `mem_rdy`: `ir_out` ← `mem_rdata`, counter clears, go to HOLD.
  - No `mem_rdy` by counter = TIMEOUT−1: go to FAULT.
  - `mem_rdy` in the timeout cycle: `mem_rdy` wins.
- HOLD:
  - `ir_valid` = 1; `ir_out` stable.
  - On `ir_ack`: register `pc_select` ← `branch_take`; register `pc_bus` ← `branch_target` if taken, else hold previous value. Go to UPDATE.
  - `branch_*` are ignored without `ir_ack`.
- UPDATE:
  - `pc_enable` = 1 for exactly this cycle; `retired` increments and wraps 0xFFFF→0x0000.
  - Next state is HALTED if `halt` = 1, else FETCH.
- HALTED: `halted` = 1; all requests deasserted. Leaves to FETCH when `halt` = 0.
- FAULT: `fault` = 1; `mem_req`, `ir_valid`, `pc_enable` = 0. Exits only on `rst`. `halt` is ignored.
- `halt` is sampled only in IDLE, UPDATE and HALTED. It never aborts a fetch or a held instruction.
- `pc_select` returns to 0 on entering FETCH, so idle PC controls are stable.

## Timing
- Reset values: `pc_enable` 0, `pc_select` 0, `pc_bus` 0, `mem_req` 0, `ir_out` 0, `ir_valid` 0, `retired` 0, `halted` 0, `fault` 0.
- `mem_req`, `ir_valid`, `pc_enable`, `halted`, `fault` are decoded from the registered state (Moore). `ir_out`, `pc_select`, `pc_bus`, `retired` are registers.
- First `mem_req` appears in the 2nd cycle after `rst` deasserts.
- Minimum instruction period is 3 cycles: FETCH with `mem_rdy` → HOLD with `ir_ack` → UPDATE.
- PC loads on the clock edge ending UPDATE. The next FETCH presents the new `pc_value` in its first cycle.
- `ir_valid` rises the cycle after the `mem_rdy` cycle. It falls the cycle after the `ir_ack` cycle.
- Timeout: with no `mem_rdy`, FAULT is entered after exactly TIMEOUT FETCH cycles.
- `rst` mid-operation (any state) returns to IDLE immediately and clears all registers, including `fault`.

## Structure
- Shared `cpu_pkg`:
  - state enum `fetch_state_t`.
  - `PC_SEL_INC` = 1'b0, `PC_SEL_BUS` = 1'b1, matching `program_counter` select encoding.
  - `RESET_IR` = 16'h0000.
- Sub-module `fetch_timeout_ctr`:
  - `$clog2(TIMEOUT)`-bit counter.
  - Inputs: `clr`, `inc`. Output: `expired` at count TIMEOUT−1.
- Top-level FSM and datapath registers live in `fetch_sequencer`.

## Test plan
- Reset, `halt` 0, PC=0x0000, `mem_rdy` in the first FETCH cycle with `mem_rdata` 0x1234, `ir_ack` one cycle later, no branch → `ir_out` = 0x1234, one `pc_enable` with `pc_select` = 0, PC reaches 0x0001, `retired` = 1, next `mem_addr` = 0x0001.
- `ir_ack` with `branch_take` = 1, `branch_target` = 0x00A0 → `pc_select` = 1 and `pc_bus` = 0x00A0 during UPDATE; next `mem_addr` = 0x00A0.
- `mem_rdy` delayed 5 cycles → `mem_req` held 6 cycles with a stable address; no fault.
- `mem_rdy` never asserted, TIMEOUT = 16 → `fault` rises after 16 FETCH cycles and stays high; `halt` toggling has no effect; `rst` clears it.
- `halt` asserted during HOLD → instruction completes, HALTED after UPDATE, `halted` = 1, no `mem_req`. Deassert `halt` → FETCH the next cycle at PC+1.
- `retired` preloaded near wrap (run 65535 instructions, or force) → increments 0xFFFF→0x0000; `rst` asserted mid-FETCH returns all outputs to reset values asynchronously.
